fpadd_arbiter: RTL and testbench
================================

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: max WAIT cycles before abort; used only with FPADD_ARB_TIMEOUT_EN.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0  in  1  requester 0 add request.
REQ-006 opa0  in  32  requester 0 operand A, IEEE-754 single.
REQ-007 opb0  in  32  requester 0 operand B.
REQ-008 req1  in  1  requester 1 add request.
REQ-009 opa1  in  32  requester 1 operand A.
REQ-010 opb1  in  32  requester 1 operand B.
REQ-011 done0  out  1  one-cycle completion pulse to requester 0.
REQ-012 done1  out  1  one-cycle completion pulse to requester 1.
REQ-013 result  out  32  sum for the completing requester.
REQ-014 err  out  1  high with done when the operation timed out.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 add_a  out  32  serial operand bus to the shared FP adder.
REQ-017 add_load  out  1  high while add_a carries a valid operand.
REQ-018 add_sum  in  32  adder sum.
REQ-019 add_ready  in  1  adder sum valid.

Function
REQ-020 States SHALL be IDLE, LOAD_A, LOAD_B, WAIT, RESP; unlisted encodings go to IDLE.
REQ-021 IDLE: a req sampled high SHALL grant and go to LOAD_A; no req stays in IDLE.
REQ-022 Arbitration SHALL be round-robin: one req -> grant it; both -> grant the one not served last; pointer updates on each grant.
REQ-023 opaN/opbN of the granted requester SHALL be latched at grant; later input changes have no effect.
REQ-024 LOAD_A: add_a = latched A, add_load = 1, one cycle, then LOAD_B.
REQ-025 LOAD_B: add_a = latched B, add_load = 1, one cycle, then WAIT.
REQ-026 Outside LOAD_A/LOAD_B, add_a SHALL be 0 and add_load 0.
REQ-027 WAIT: add_ready = 1 SHALL capture add_sum into result and go to RESP; add_ready in any other state is ignored.
REQ-028 RESP: done of granted requester = 1 for exactly one cycle, then IDLE; doneN never both high.
REQ-029 result SHALL hold its value until the next capture.
REQ-030 Minimum latency: req sampled in IDLE at cycle 0 -> done at cycle 4 (add_ready high in first WAIT cycle).
REQ-031 Requester dropping req mid-operation SHALL NOT abort; done still pulses.
REQ-032 req still high in IDLE after RESP SHALL count as a new request (requester drops req the cycle after done).

Reset
REQ-033 reset SHALL force IDLE, done0/done1/err/busy/add_load = 0, result/add_a = 0, pointer favouring req0 on first tie.
REQ-034 reset mid-operation SHALL abandon it with no done pulse; adder output is ignored until a new grant reaches WAIT.

Configuration
REQ-035 With FPADD_ARB_TIMEOUT_EN defined: a counter runs in WAIT; after TIMEOUT_CYCLES cycles without add_ready, go to RESP with result = 32'h7FC00000 and err = 1 alongside done.
REQ-036 Without FPADD_ARB_TIMEOUT_EN: WAIT SHALL last indefinitely, err tied 0, no counter logic.

Verification
REQ-037 req0, opa0=3F800000, opb0=40000000, add_ready in first WAIT with add_sum=40400000 -> add_a 3F800000 then 40000000, done0 at cycle 4, result 40400000.
REQ-038 req0 and req1 raised together, held and re-raised after each done -> grants alternate 0,1,0,1; never both done.
REQ-039 Change opa0 during LOAD_B/WAIT -> add_a and result unaffected.
REQ-040 reset asserted in WAIT -> IDLE next cycle, no done, busy 0; next request completes normally.
REQ-041 FPADD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, add_ready held 0 -> done with err=1, result 7FC00000 after 16 WAIT cycles; without macro busy stays 1.

Source files
------------

// File: rtl/fpadd_arbiter.sv
// Two-requester round-robin front end for a shared serial-operand FP adder.
// Optional WAIT timeout is compiled in with `define FPADD_ARB_TIMEOUT_EN.
module fpadd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] opa0,
  input  logic [31:0] opb0,
  input  logic        req1,
  input  logic [31:0] opa1,
  input  logic [31:0] opb1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        err,
  output logic        busy,
  output logic [31:0] add_a,
  output logic        add_load,
  input  logic [31:0] add_sum,
  input  logic        add_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("fpadd_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic        last_q, last_d;   // requester served most recently
  logic        gnt_q, gnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;

`ifdef FPADD_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef FPADD_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef FPADD_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done0    = 1'b0;
    done1    = 1'b0;
    add_a    = '0;
    add_load = 1'b0;
    busy     = (state_q != IDLE);
`ifdef FPADD_ARB_TIMEOUT_EN
    cnt_d    = '0;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          last_d  = gnt_d;
          a_d     = gnt_d ? opa1 : opa0;
          b_d     = gnt_d ? opb1 : opb0;
          state_d = LOAD_A;
`ifdef FPADD_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      LOAD_A: begin
        add_a    = a_q;
        add_load = 1'b1;
        state_d  = LOAD_B;
      end
      LOAD_B: begin
        add_a    = b_q;
        add_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (add_ready) begin
          result_d = add_sum;
          state_d  = RESP;
        end
`ifdef FPADD_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          result_d = 32'h7FC0_0000;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        done0   = ~gnt_q;
        done1   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = result_q;

`ifdef FPADD_ARB_TIMEOUT_EN
  assign err = (state_q == RESP) && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scoreboard bench for fpadd_arbiter: directed requests, a scripted adder
// responder, and a monitor checking operand bus and completions.
module tb_fpadd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] opa0, opb0, opa1, opb1;
  logic        done0, done1, err, busy, add_load, add_ready;
  logic [31:0] result, add_a, add_sum;

  fpadd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .opa0(opa0), .opb0(opb0),
    .req1(req1), .opa1(opa1), .opb1(opb1),
    .done0(done0), .done1(done1), .result(result), .err(err), .busy(busy),
    .add_a(add_a), .add_load(add_load), .add_sum(add_sum), .add_ready(add_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    logic [31:0] res;
    bit          err;
    int          at;
  } exp_t;

  exp_t        resp_q[$];
  logic [31:0] load_q[$];
  logic [31:0] sum_q[$];

  int vectors     = 0;
  int miscompares = 0;

  bit rsp_en    = 1'b1;
  bit spurious  = 1'b0;
  int rsp_delay = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_resp(input bit port, input logic [31:0] r, input bit e, input int at);
    exp_t x;
    x.port = port; x.res = r; x.err = e; x.at = at;
    resp_q.push_back(x);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done0 || done1) begin
        chk("done_exclusive", {31'b0, done0 & done1}, 32'd0);
        if (resp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done0=%b done1=%b expected none (cycle %0d)", done0, done1, cyc);
        end else begin
          e = resp_q.pop_front();
          chk("done_port", {31'b0, done1}, {31'b0, e.port});
          chk("result", result, e.res);
          chk("err", {31'b0, err}, {31'b0, e.err});
          if (e.at >= 0) chk("latency", cyc, e.at);
        end
      end else begin
        chk("err_idle", {31'b0, err}, 32'd0);
      end
      if (add_load) begin
        if (load_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_load: got add_a=%h expected no load (cycle %0d)", add_a, cyc);
        end else begin
          chk("add_a", add_a, load_q.pop_front());
        end
      end else begin
        chk("add_a_idle", add_a, 32'd0);
      end
    end
  end

  // Adder responder: answers in the first WAIT cycle plus rsp_delay
  initial begin
    bit ld;
    ld        = 1'b0;
    add_ready = 1'b0;
    add_sum   = '0;
    forever begin
      @(negedge clock);
      add_ready = 1'b0;
      if (reset) begin
        ld = 1'b0;
      end else if (add_load) begin
        if (!ld) begin
          ld = 1'b1;
        end else begin
          ld = 1'b0;
          if (spurious) begin
            add_ready = 1'b1;
            add_sum   = 32'hBADB_AD00;
          end
          if (rsp_en) begin
            repeat (1 + rsp_delay) begin
              @(negedge clock);
              add_ready = 1'b0;
            end
            add_ready = 1'b1;
            add_sum   = sum_q.pop_front();
          end
        end
      end
    end
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: got no end of stimulus expected finish (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int c;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
    tick(2);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done0", {31'b0, done0}, 32'd0);
    chk("rst_done1", {31'b0, done1}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_add_load", {31'b0, add_load}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    reset = 1'b0;
    tick(2);

    // 1.0 + 2.0 on requester 0, minimum latency, operands disturbed after grant
    c = cyc;
    req0 = 1'b1; opa0 = 32'h3F80_0000; opb0 = 32'h4000_0000;
    load_q.push_back(32'h3F80_0000); load_q.push_back(32'h4000_0000);
    sum_q.push_back(32'h4040_0000);
    expect_resp(1'b0, 32'h4040_0000, 1'b0, c + 4);
    tick(1); req0 = 1'b0;
    chk("busy_load_a", {31'b0, busy}, 32'd1);
    tick(1); opa0 = 32'hDEAD_BEEF; opb0 = 32'h1234_5678;
    tick(1); opa0 = 32'hCAFE_F00D;
    tick(4);
    chk("result_hold", result, 32'h4040_0000);

    // 5.0 + 0.5 on requester 1, two extra WAIT cycles, stray add_ready in LOAD_B
    rsp_delay = 2; spurious = 1'b1;
    c = cyc;
    req1 = 1'b1; opa1 = 32'h40A0_0000; opb1 = 32'h3F00_0000;
    load_q.push_back(32'h40A0_0000); load_q.push_back(32'h3F00_0000);
    sum_q.push_back(32'h40B0_0000);
    expect_resp(1'b1, 32'h40B0_0000, 1'b0, c + 6);
    tick(1); req1 = 1'b0;
    tick(8);
    rsp_delay = 0; spurious = 1'b0;

    // Reset while in WAIT abandons the operation
    rsp_en = 1'b0;
    c = cyc;
    req0 = 1'b1; opa0 = 32'h3F80_0000; opb0 = 32'h3F80_0000;
    load_q.push_back(32'h3F80_0000); load_q.push_back(32'h3F80_0000);
    tick(1); req0 = 1'b0;
    tick(2);
    chk("busy_wait", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_add_load", {31'b0, add_load}, 32'd0);
    tick(3);
    rsp_en = 1'b1;

    // Both held: grants alternate 0,1,0,1 starting with requester 0
    c = cyc;
    req0 = 1'b1; opa0 = 32'h3F80_0000; opb0 = 32'h3F80_0000;
    req1 = 1'b1; opa1 = 32'h4000_0000; opb1 = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        load_q.push_back(32'h3F80_0000); load_q.push_back(32'h3F80_0000);
        sum_q.push_back(32'h4000_0000);
        expect_resp(1'b0, 32'h4000_0000, 1'b0, c + 4 + 5 * i);
      end else begin
        load_q.push_back(32'h4000_0000); load_q.push_back(32'h4000_0000);
        sum_q.push_back(32'h4080_0000);
        expect_resp(1'b1, 32'h4080_0000, 1'b0, c + 4 + 5 * i);
      end
    end
    tick(19);
    req0 = 1'b0; req1 = 1'b0;
    tick(3);
    chk("rr_idle_busy", {31'b0, busy}, 32'd0);

    // Adder never answers
    rsp_en = 1'b0;
    c = cyc;
    req0 = 1'b1; opa0 = 32'h4040_0000; opb0 = 32'h4040_0000;
    load_q.push_back(32'h4040_0000); load_q.push_back(32'h4040_0000);
`ifdef FPADD_ARB_TIMEOUT_EN
    expect_resp(1'b0, 32'h7FC0_0000, 1'b1, c + 19);
`endif
    tick(1); req0 = 1'b0;
    tick(9);
`ifndef FPADD_ARB_TIMEOUT_EN
    chk("stall_busy_early", {31'b0, busy}, 32'd1);
`endif
    tick(15);
`ifdef FPADD_ARB_TIMEOUT_EN
    chk("timeout_busy", {31'b0, busy}, 32'd0);
    chk("timeout_result_hold", result, 32'h7FC0_0000);
`else
    chk("stall_busy_late", {31'b0, busy}, 32'd1);
`endif
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rsp_en = 1'b1;
    tick(1);

    // Normal operation after reset: -1.0 + 2.0 on requester 1
    c = cyc;
    req1 = 1'b1; opa1 = 32'hBF80_0000; opb1 = 32'h4000_0000;
    load_q.push_back(32'hBF80_0000); load_q.push_back(32'h4000_0000);
    sum_q.push_back(32'h3F80_0000);
    expect_resp(1'b1, 32'h3F80_0000, 1'b0, c + 4);
    tick(1); req1 = 1'b0;
    tick(6);

    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("load_q_drained", load_q.size(), 32'd0);
    chk("sum_q_drained", sum_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
